// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Instruction-fetch stage feeding the IF/ID pipeline register
//
// Owns the PC, fetches from a variable-latency instruction memory over a
// req/ack handshake, and presents {instruction, PC+4, valid} to IF/ID.
// Hazard stalls park an early-arriving instruction in a one-entry hold
// buffer. Branch/jump redirects flush IF/ID and discard any in-flight fetch.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   stall_i               hazard stall: hold IF outputs and PC
//   branch_i/_addr_i      taken branch and its target (wins over jump)
//   jump_i/_addr_i        jump and its target
//   flush_o               IF/ID flush, branch_i | jump_i
//   imem_req_o/_addr_o    fetch request and word-aligned address
//   imem_ack_i/_data_i    response strobe and instruction word
//   inst_addr_o           PC+4 of the presented instruction
//   inst_o, inst_valid_o  presented instruction, 0 valid means bubble

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        flush_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] drain_addr, drain_addr_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic [31:0] hold_addr, hold_addr_n;
  logic        hold_full, hold_full_n;
  logic [31:0] out_inst, out_inst_n;
  logic [31:0] out_addr, out_addr_n;
  logic        out_valid, out_valid_n;
  // Cleared by reset so that req stays low until the first cycle after
  // rst_n_i deasserts, and drops the instant reset is asserted.
  logic        started;

  logic        redirect;
  logic [31:0] target;
  logic        ack;
  logic [31:0] pc_plus4;

  assign redirect = branch_i | jump_i;
  assign target   = branch_i ? {branch_addr_i[31:2], 2'b00}
                             : {jump_addr_i[31:2], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  assign flush_o      = redirect;
  assign imem_req_o   = started & (state != HOLD);
  // DRAIN keeps presenting the abandoned address while pc already holds
  // the redirect target.
  assign imem_addr_o  = (state == DRAIN) ? drain_addr : pc;
  assign ack          = imem_ack_i & imem_req_o;

  assign inst_o       = out_inst;
  assign inst_addr_o  = out_addr;
  assign inst_valid_o = out_valid;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drain_addr_n = drain_addr;
    hold_inst_n  = hold_inst;
    hold_addr_n  = hold_addr;
    hold_full_n  = hold_full;
    out_inst_n   = out_inst;
    out_addr_n   = out_addr;
    out_valid_n  = out_valid;

    if (started) begin
      if (redirect) begin
        pc_n        = target;
        out_inst_n  = NOP_INST;
        out_valid_n = 1'b0;
        hold_full_n = 1'b0;
      end

      unique case (state)
        FETCH: begin
          if (redirect) begin
            if (!ack) begin
              state_n      = DRAIN;
              drain_addr_n = pc;
            end
          end else if (ack) begin
            pc_n = pc_plus4;
            if (stall_i) begin
              hold_inst_n = imem_data_i;
              hold_addr_n = pc_plus4;
              hold_full_n = 1'b1;
              state_n     = HOLD;
            end else begin
              out_inst_n  = imem_data_i;
              out_addr_n  = pc_plus4;
              out_valid_n = 1'b1;
            end
          end else if (!stall_i) begin
            out_inst_n  = NOP_INST;
            out_valid_n = 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            state_n = FETCH;
          end else if (!stall_i) begin
            out_inst_n  = hold_full ? hold_inst : NOP_INST;
            out_addr_n  = hold_addr;
            out_valid_n = hold_full;
            hold_full_n = 1'b0;
            state_n     = FETCH;
          end
        end

        DRAIN: begin
          out_inst_n  = NOP_INST;
          out_valid_n = 1'b0;
          if (ack) begin
            state_n = FETCH;
          end
        end

        default: begin
          state_n = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= FETCH;
      started    <= 1'b0;
      pc         <= RESET_PC_ALIGNED;
      drain_addr <= 32'd0;
      hold_inst  <= NOP_INST;
      hold_addr  <= 32'd0;
      hold_full  <= 1'b0;
      out_inst   <= NOP_INST;
      out_addr   <= 32'd0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      started    <= 1'b1;
      pc         <= pc_n;
      drain_addr <= drain_addr_n;
      hold_inst  <= hold_inst_n;
      hold_addr  <= hold_addr_n;
      hold_full  <= hold_full_n;
      out_inst   <= out_inst_n;
      out_addr   <= out_addr_n;
      out_valid  <= out_valid_n;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory using a req/ack handshake.
- Presents the fetched instruction and its PC+4 to IF/ID.
- Honours hazard stalls, and handles branch/jump redirects by flushing and discarding any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word driven while inst_valid_o=0.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- stall_i  input  1  hazard stall from the hazard unit; hold IF outputs and PC.
- branch_i  input  1  branch taken, resolved in ID.
- branch_addr_i  input  32  branch target.
- jump_i  input  1  jump decoded in ID.
- jump_addr_i  input  32  full jump target.
- flush_o  output  1  flush of IF/ID; combinational, equals branch_i | jump_i.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address; word aligned.
- imem_ack_i  input  1  response valid; data is valid in the same cycle.
- imem_data_i  input  32  instruction word.
- inst_addr_o  output  32  PC+4 of the presented instruction, to IF/ID inst_addr_i.
- inst_o  output  32  presented instruction, to IF/ID inst_i.
- inst_valid_o  output  1  inst_o holds a real instruction; 0 means bubble.

Behaviour:

Reset (asynchronous, rst_n_i=0):
- pc=RESET_PC, state=FETCH, drain=0, hold buffer empty.
- imem_req_o=0, inst_o=NOP_INST, inst_addr_o=0, inst_valid_o=0.
- First request is issued in the cycle after rst_n_i deasserts.
- Reset during an outstanding request drops imem_req_o immediately. The memory must abandon the request; a late ack is ignored because req=0.

Handshake:
- imem_req_o and imem_addr_o are held stable until the cycle imem_ack_i=1.
- An ack is accepted only while imem_req_o=1.
- Zero-wait ack (ack in the first req cycle) is legal.
- Back-to-back fetches: after an accepted ack, req stays high with the next address in the following cycle.
- Sustained throughput is 1 instruction/cycle with zero-wait memory.

States:
- FETCH: req=1, addr=pc.
  - Ack, no redirect, stall_i=0: outputs load {inst=imem_data_i, addr=pc+4, valid=1}; pc<=pc+4; remain in FETCH.
  - Ack, no redirect, stall_i=1: outputs hold; data and pc+4 go into the hold buffer; pc<=pc+4; go to HOLD.
  - No ack, stall_i=0: outputs become a bubble (valid=0, inst=NOP_INST).
  - No ack, stall_i=1: outputs hold.
- HOLD: req=0.
  - stall_i=0: outputs load from the hold buffer, valid=1; go to FETCH.
  - stall_i=1: remain in HOLD.
- DRAIN: req=1 with the old address still held; waits for the ack of the abandoned request.
  - On ack: data discarded; go to FETCH at the redirected pc.
  - Outputs are a bubble throughout.

Redirect (branch_i | jump_i):
- Redirect has priority over stall_i.
- branch_i has priority over jump_i if both are asserted.
- Effects at the clock edge:
  - pc <= target with bits [1:0] forced to 0.
  - Outputs become a bubble.
  - Hold buffer is cleared.
- In FETCH with an ack in the same cycle: fetched data is discarded; next cycle goes to FETCH at the target.
- In FETCH without an ack: go to DRAIN (the address must not change mid-request); the target is latched into pc.
- In HOLD: go to FETCH at the target.
- In DRAIN: pc is updated to the newest target; stay in DRAIN.

Arithmetic:
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- imem_addr_o[1:0] is always 0.

Test Plan:
1. Reset, zero-wait memory returning addr-based data, no stall -> imem_addr_o sequence 0,4,8,C; inst_addr_o 4,8,C,10 one cycle later; inst_valid_o=1 continuously from the second post-reset cycle.
2. Memory with 2 wait states -> each request is held 3 cycles with a stable address; inst_valid_o pulses 1 cycle in every 3, with bubbles between.
3. stall_i high for 3 cycles coincident with an ack at addr 8 -> outputs frozen; req low in HOLD; on release, inst_addr_o=C with the addr-8 data and valid=1, then fetch resumes at C.
4. branch_i=1, branch_addr_i=32'h0000_0103 while a request to 10 is pending with 2 wait states -> flush_o=1 that cycle; DRAIN keeps addr 10 until ack; the ack data never appears on inst_o; the next request goes to 100.
5. branch_i and jump_i together with stall_i=1 (targets 200/300), ack in the same cycle -> pc=200; the acked data is dropped; the next request is to 200 despite the stall.
6. RESET_PC=32'hFFFF_FFFC, zero-wait memory -> addresses FFFF_FFFC then 0; inst_addr_o=0 for the first instruction. Asserting rst_n_i low mid-request drops req the same cycle, with outputs at reset values.
